cache_axi_arbiter: RTL and testbench

Shares the single AXI4 master port of the CPU core between the instruction cache and the data cache. Read misses from both caches are arbitrated onto one AXI read channel, one burst in flight at a time. Dirty-line write-backs from the data cache run on the AXI write channels, concurrently with instruction-cache reads. Its response timing is the source of the `i_cache_stall` and `d_cache_stall` levels seen by the hazard unit.

---
 rtl/axi_pkg.sv | 38 +++
 rtl/axi_wr_fsm.sv | 97 +++++++++
 rtl/cache_axi_arbiter.sv | 158 +++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared types and constants for the cache-to-AXI arbiter:
//   rd_state_e / wr_state_e : read and write channel FSM encodings
//   owner_e                 : which cache owns the current read burst
//   AXI_SIZE_4B, AXI_BURST_INCR, WSTRB_ALL : fixed AXI burst attributes
//   axi_len()               : AXI LEN field for a burst of N words
// -----------------------------------------------------------------------------
package axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] WSTRB_ALL      = 4'hF;

  // AXI encodes burst length as beats minus one.
  function automatic logic [7:0] axi_len(input int unsigned words);
    return 8'(words - 1);
  endfunction

endpackage

// File: rtl/axi_wr_fsm.sv
// -----------------------------------------------------------------------------
// axi_wr_fsm
// Runs D-cache dirty-line write-backs on the AXI AW/W/B channels.
// Ports:
//   clk, rst               : core clock, asynchronous active-low reset
//   d_wr_req, d_wr_addr    : write-back request and line-aligned address
//   d_wdata, d_wready      : current beat from the D-cache / beat accepted
//   d_wr_done              : one-cycle pulse on the write response
//   awaddr, awvalid, awready          : AXI write address channel
//   wdata, wlast, wvalid, wready      : AXI write data channel
//   bvalid, bready                    : AXI write response channel
//   wr_idle                : high in W_IDLE; gates D-cache read grants
// -----------------------------------------------------------------------------
module axi_wr_fsm
  import axi_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_wr_req,
  input  logic [31:0] d_wr_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic        d_wr_done,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic        wr_idle
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  wr_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      awaddr_q;
  logic             awvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= W_IDLE;
      cnt_q     <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (d_wr_req) begin
            awaddr_q  <= d_wr_addr;
            cnt_q     <= '0;
            awvalid_q <= 1'b1;
            state_q   <= W_AW;
          end
        end
        W_AW: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            state_q   <= W_DATA;
          end
        end
        W_DATA: begin
          // wvalid is constantly high here, so wready alone is the handshake.
          if (wready) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bvalid) begin
            state_q <= W_IDLE;
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = (state_q == W_DATA);
  assign wdata     = d_wdata;
  assign d_wready  = wvalid & wready;
  assign wlast     = wvalid & (cnt_q == LAST_BEAT);
  assign bready    = (state_q == W_RESP);
  assign d_wr_done = bready & bvalid;
  assign wr_idle   = (state_q == W_IDLE);

endmodule

// File: rtl/cache_axi_arbiter.sv
// -----------------------------------------------------------------------------
// cache_axi_arbiter
// Shares one AXI4 master between the I-cache and D-cache. Line fills from
// both caches are arbitrated onto the read channel, one burst at a time;
// D-cache write-backs run on the write channels in parallel.
// Ports:
//   clk, rst                        : core clock, asynchronous active-low reset
//   i_rd_req/i_rd_addr/i_rvalid     : I-cache fill request and beat strobe
//   d_rd_req/d_rd_addr/d_rvalid     : D-cache fill request and beat strobe
//   rdata, rlast                    : beat data / last marker for both caches
//   d_wr_req/d_wr_addr/d_wdata      : D-cache write-back request and data
//   d_wready, d_wr_done             : beat accepted / write-back complete
//   ar*, r*                         : AXI read address and read data channels
//   aw*, w*, b*                     : AXI write channels
// -----------------------------------------------------------------------------
module cache_axi_arbiter
  import axi_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  output logic        i_rvalid,
  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  output logic        d_rvalid,
  output logic [31:0] rdata,
  output logic        rlast,
  input  logic        d_wr_req,
  input  logic [31:0] d_wr_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic        d_wr_done,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata_axi,
  input  logic        rlast_axi,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [7:0] BURST_LEN = axi_len(LINE_WORDS);

  rd_state_e   r_state_q;
  owner_e      owner_q;
  owner_e      last_owner_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        wr_idle;
  logic        d_elig;
  logic        grant_d;
  logic        in_data;

  // A D-cache fill waits for its own write-back to finish so the refetch
  // can never overtake the dirty data heading to memory.
  assign d_elig  = d_rd_req & wr_idle;
  // On a tie the cache that did not own the previous burst wins.
  assign grant_d = d_elig & (~i_rd_req | (last_owner_q == OWN_I));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q    <= R_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_D;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (i_rd_req | d_elig) begin
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
            if (grant_d) begin
              owner_q      <= OWN_D;
              last_owner_q <= OWN_D;
              araddr_q     <= d_rd_addr;
            end else begin
              owner_q      <= OWN_I;
              last_owner_q <= OWN_I;
              araddr_q     <= i_rd_addr;
            end
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid & rlast_axi) begin
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign in_data  = (r_state_q == R_DATA);
  assign rready   = in_data;
  assign i_rvalid = in_data & rvalid & (owner_q == OWN_I);
  assign d_rvalid = in_data & rvalid & (owner_q == OWN_D);
  assign rdata    = rdata_axi;
  assign rlast    = rlast_axi;

  assign araddr   = araddr_q;
  assign arvalid  = arvalid_q;
  assign arlen    = BURST_LEN;
  assign arsize   = AXI_SIZE_4B;
  assign arburst  = AXI_BURST_INCR;
  assign awlen    = BURST_LEN;
  assign awsize   = AXI_SIZE_4B;
  assign awburst  = AXI_BURST_INCR;
  assign wstrb    = WSTRB_ALL;

  axi_wr_fsm #(
    .LINE_WORDS(LINE_WORDS)
  ) u_wr_fsm (
    .clk      (clk),
    .rst      (rst),
    .d_wr_req (d_wr_req),
    .d_wr_addr(d_wr_addr),
    .d_wdata  (d_wdata),
    .d_wready (d_wready),
    .d_wr_done(d_wr_done),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready),
    .wr_idle  (wr_idle)
  );

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_axi_arbiter
// Self-checking bench: arbitration vectors in a table, read beats tracked
// through a scoreboard queue, hand-written sequences for write-back ordering,
// AR back-pressure and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_cache_axi_arbiter;
  import axi_pkg::*;

  localparam int          LW    = 8;
  localparam logic [31:0] WBASE = 32'hA500_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd_req = 1'b0, d_rd_req = 1'b0, d_wr_req = 1'b0;
  logic [31:0] i_rd_addr = '0, d_rd_addr = '0, d_wr_addr = '0, d_wdata = '0;
  logic        arready = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        rvalid = 1'b0, rlast_axi = 1'b0;
  logic [31:0] rdata_axi = '0;
  logic        i_rvalid, d_rvalid, rlast, d_wready, d_wr_done;
  logic [31:0] rdata, araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic [3:0]  wstrb;

  cache_axi_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rvalid(i_rvalid),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rvalid(d_rvalid),
    .rdata(rdata), .rlast(rlast),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wdata(d_wdata),
    .d_wready(d_wready), .d_wr_done(d_wr_done),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata_axi(rdata_axi), .rlast_axi(rlast_axi), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    owner_e      own;
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sb_q[$];
  beat_t mon_e;

  int i_beats = 0, d_beats = 0, wr_pulses = 0, done_pulses = 0, wlast_cnt = 0;
  int w_acc = 0, ar_out = 0;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      w_acc  = 0;
      ar_out = 0;
    end else begin
      if (arvalid && arready) begin
        chk("ar_single_outstanding", ar_out, 0);
        ar_out++;
      end
      if (i_rvalid || d_rvalid) begin
        chk("rvalid_exclusive", i_rvalid & d_rvalid, 0);
        if (i_rvalid) i_beats++;
        if (d_rvalid) d_beats++;
        if (sb_q.size() == 0) begin
          chk("rd_unexpected_beat", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rd_owner", d_rvalid, mon_e.own);
          chk("rd_data", rdata, mon_e.data);
          chk("rd_last", rlast, mon_e.last);
          if (rlast) ar_out--;
        end
      end
      if (d_wready) wr_pulses++;
      if (wvalid && wready) begin
        chk("wdata", wdata, WBASE + 32'(w_acc));
        chk("wlast", wlast, (w_acc == LW - 1));
        chk("wstrb", wstrb, 4'hF);
        if (wlast) wlast_cnt++;
        w_acc = (w_acc == LW - 1) ? 0 : w_acc + 1;
      end
      if (d_wr_done) done_pulses++;
    end
  end

  // ---------------- drivers ----------------
  task automatic chk_quiet();
    chk("q_arvalid", arvalid, 0);
    chk("q_awvalid", awvalid, 0);
    chk("q_wvalid", wvalid, 0);
    chk("q_rready", rready, 0);
    chk("q_bready", bready, 0);
    chk("q_d_wready", d_wready, 0);
    chk("q_d_wr_done", d_wr_done, 0);
    chk("q_i_rvalid", i_rvalid, 0);
    chk("q_d_rvalid", d_rvalid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_rd_req = 0; d_rd_req = 0; d_wr_req = 0; arready = 0; awready = 0;
    rlast_axi = 0; rvalid = 1; wready = 1; bvalid = 1;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet();
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    rvalid = 0; wready = 0; bvalid = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One read burst; abort_at < LW asserts reset while that beat is on the bus.
  task automatic run_read(input owner_e own, input logic [31:0] addr, input int ar_delay,
                          input bit gaps, input bit drop_i, input bit drop_d,
                          input bit raise_d, input int abort_at, output int ar_cyc);
    int k;
    bit seen;
    logic [31:0] beat;
    seen = 0;
    ar_cyc = -1;
    for (k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (arvalid) seen = 1;
    end
    chk("ar_seen", seen, 1);
    if (!seen) return;
    ar_cyc = cyc;
    chk("araddr", araddr, addr);
    chk("arlen", arlen, LW - 1);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    for (int j = 0; j < ar_delay; j++) begin
      if (raise_d && j == 0) begin
        d_rd_req = 1; d_rd_addr = 32'h0000_5000;
      end
      @(negedge clk);
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, addr);
    end
    arready = 1;
    @(negedge clk);
    arready = 0;
    chk("ar_drop", arvalid, 0);
    chk("rready_data", rready, 1);
    for (int b = 0; b < LW; b++) begin
      if (gaps && (b % 3) == 1) begin
        rvalid = 0; rlast_axi = 0;
        @(negedge clk);
      end
      beat = (addr ^ 32'h5A5A_0000) + 32'(b * 4);
      rvalid = 1; rdata_axi = beat; rlast_axi = (b == LW - 1);
      if (b == abort_at) begin
        rst = 1'b0;
        #1;
        chk_quiet();
        rvalid = 0; rlast_axi = 0; i_rd_req = 0; d_rd_req = 0;
        return;
      end
      sb_q.push_back('{own, beat, (b == LW - 1)});
      @(negedge clk);
    end
    rvalid = 0; rlast_axi = 0;
    if (drop_i) i_rd_req = 0;
    if (drop_d) d_rd_req = 0;
    chk("rready_idle", rready, 0);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  // One write-back with wready toggling 1,0,1,...; abort_at < LW resets mid-burst.
  task automatic run_write(input logic [31:0] addr, input int bdelay, input int abort_at,
                           output int done_cyc);
    int k;
    int idx;
    bit seen;
    seen = 0;
    done_cyc = -1;
    d_wr_req = 1; d_wr_addr = addr;
    for (k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (awvalid) seen = 1;
    end
    chk("aw_seen", seen, 1);
    if (!seen) begin
      d_wr_req = 0;
      return;
    end
    chk("awaddr", awaddr, addr);
    chk("awlen", awlen, LW - 1);
    chk("awsize_burst", {awsize, awburst}, 5'b010_01);
    awready = 1;
    @(negedge clk);
    awready = 0;
    chk("aw_drop", awvalid, 0);
    idx = 0;
    for (k = 0; k < 64 && idx < LW; k++) begin
      wready = ((k % 2) == 0);
      d_wdata = WBASE + 32'(idx);
      if (wready && idx == abort_at) begin
        rst = 1'b0;
        #1;
        chk_quiet();
        chk("rst_wlast", wlast, 0);
        wready = 0; d_wr_req = 0;
        return;
      end
      #1;
      if (d_wready) idx++;
      @(negedge clk);
    end
    wready = 0;
    chk("w_beats_accepted", idx, LW);
    chk("bready_resp", bready, 1);
    for (int j = 0; j < bdelay; j++) @(negedge clk);
    bvalid = 1;
    #1;
    chk("wr_done_pulse", d_wr_done, 1);
    done_cyc = cyc;
    @(negedge clk);
    bvalid = 0; d_wr_req = 0;
    chk("wr_done_low", d_wr_done, 0);
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    logic        i_req;
    logic        d_req;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    owner_e      exp_own;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c, c2, req_cyc, done_cyc, i_end;
    int ib0, db0, wp0, dp0, wl0;

    // Last owner after the I-only burst of the first sequence is I.
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, OWN_D, 32'h0000_0200};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0140, 32'h0000_0240, OWN_I, 32'h0000_0140};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0180, 32'h0000_0280, OWN_D, 32'h0000_0280};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_01C0, 32'h0000_02C0, OWN_I, 32'h0000_01C0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0000_0400, OWN_I, 32'h0000_0300};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0340, 32'h0000_0440, OWN_D, 32'h0000_0440};

    do_reset();

    // I-cache only, arready in 2nd AR cycle, beat gaps, 1-cycle request-to-AR.
    ib0 = i_beats; db0 = d_beats;
    i_rd_req = 1; i_rd_addr = 32'h1FC0_0000;
    req_cyc = cyc;
    run_read(OWN_I, 32'h1FC0_0000, 1, 1'b1, 1'b1, 1'b1, 1'b0, LW, c);
    $display("txn I-only fill 0x1FC00000: AR at cycle %0d", c);
    chk("t1_ar_latency", c - req_cyc, 1);
    chk("t1_i_beats", i_beats - ib0, 8);
    chk("t1_d_beats", d_beats - db0, 0);

    // Table-driven grants.
    for (int v = 0; v < 6; v++) begin
      i_rd_req = vecs[v].i_req; d_rd_req = vecs[v].d_req;
      i_rd_addr = vecs[v].i_addr; d_rd_addr = vecs[v].d_addr;
      run_read(vecs[v].exp_own, vecs[v].exp_addr, v % 3, (v % 2) == 1,
               1'b1, 1'b1, 1'b0, LW, c);
      $display("txn vector %0d: expected owner %0d addr 0x%08h", v, vecs[v].exp_own, vecs[v].exp_addr);
    end

    // Both held after reset: I, D, I, D.
    do_reset();
    i_rd_req = 1; i_rd_addr = 32'h0000_B000;
    d_rd_req = 1; d_rd_addr = 32'h0000_C000;
    run_read(OWN_I, 32'h0000_B000, 0, 1'b0, 1'b0, 1'b0, 1'b0, LW, c);
    run_read(OWN_D, 32'h0000_C000, 1, 1'b0, 1'b0, 1'b0, 1'b0, LW, c);
    run_read(OWN_I, 32'h0000_B000, 0, 1'b1, 1'b0, 1'b0, 1'b0, LW, c);
    run_read(OWN_D, 32'h0000_C000, 0, 1'b0, 1'b1, 1'b1, 1'b0, LW, c);
    $display("txn round-robin I,D,I,D done");

    // Write-back then D read; I burst completes during the write.
    ib0 = i_beats; db0 = d_beats; wp0 = wr_pulses; dp0 = done_pulses; wl0 = wlast_cnt;
    i_end = -1; c2 = -1; done_cyc = -1;
    fork
      run_write(32'h0000_1000, 5, LW, done_cyc);
      begin
        @(negedge clk);
        @(negedge clk);
        d_rd_req = 1; d_rd_addr = 32'h0000_2000;
        i_rd_req = 1; i_rd_addr = 32'h0000_3000;
        run_read(OWN_I, 32'h0000_3000, 0, 1'b0, 1'b1, 1'b0, 1'b0, LW, c);
        i_end = cyc;
        run_read(OWN_D, 32'h0000_2000, 0, 1'b0, 1'b1, 1'b1, 1'b0, LW, c2);
      end
    join
    $display("txn write-back 0x1000 done at %0d, D read AR at %0d", done_cyc, c2);
    chk("wb_d_ar_after_done", c2 - done_cyc, 2);
    chk("wb_i_within_write", i_end < done_cyc, 1);
    chk("wb_wready_pulses", wr_pulses - wp0, 8);
    chk("wb_done_pulses", done_pulses - dp0, 1);
    chk("wb_wlast_count", wlast_cnt - wl0, 1);
    chk("wb_i_beats", i_beats - ib0, 8);
    chk("wb_d_beats", d_beats - db0, 8);

    // AR back-pressure for 10 cycles while d_rd_req rises.
    i_rd_req = 1; i_rd_addr = 32'h0000_4000;
    run_read(OWN_I, 32'h0000_4000, 10, 1'b0, 1'b1, 1'b0, 1'b1, LW, c);
    run_read(OWN_D, 32'h0000_5000, 0, 1'b0, 1'b1, 1'b1, 1'b0, LW, c);
    $display("txn AR back-pressure 10 cycles done");

    // Reset at beat 3 of a read, then a tie must go to I again.
    i_rd_req = 1; i_rd_addr = 32'h0000_6000;
    run_read(OWN_I, 32'h0000_6000, 0, 1'b0, 1'b1, 1'b1, 1'b0, 3, c);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_rd_idle", arvalid, 0);
    i_rd_req = 1; i_rd_addr = 32'h0000_7000;
    d_rd_req = 1; d_rd_addr = 32'h0000_8000;
    run_read(OWN_I, 32'h0000_7000, 0, 1'b0, 1'b1, 1'b1, 1'b0, LW, c);
    $display("txn reset mid-read and recovery done");

    // Reset at beat 3 of a write, then a full write-back.
    run_write(32'h0000_9000, 0, 3, done_cyc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_idle", awvalid, 0);
    dp0 = done_pulses;
    run_write(32'h0000_A000, 1, LW, done_cyc);
    @(negedge clk);
    chk("post_rst_wr_done", done_pulses - dp0, 1);
    $display("txn reset mid-write and recovery done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
